// File: rtl/clock_div_bank.sv
// Bank of independent programmable clock dividers. Each channel emits a registered
// square wave plus a toggle strobe; divisor updates pass through a one-entry slot.
module clock_div_bank #(
  parameter int                NUM_CH      = 2,
  parameter int                CNT_W       = 32,
  parameter logic [CNT_W-1:0]  DEFAULT_DIV = 32'd99_999,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic              p_valid_reg;
  logic              p_valid_next;
  logic [CH_W-1:0]   p_ch_reg;
  logic [CNT_W-1:0]  p_div_reg;
  logic              cfg_accept;
  logic [NUM_CH-1:0] apply_hit;
  logic [NUM_CH-1:0] applied;

  assign cfg_ready  = ~p_valid_reg;
  assign cfg_accept = cfg_valid & ~p_valid_reg;

  // Accept and apply are mutually exclusive: accept needs an empty slot, apply a full one.
  always_comb begin
    p_valid_next = p_valid_reg;
    if (cfg_accept) begin
      p_valid_next = ({1'b0, cfg_ch} < NUM_CH_V);
    end else if (sync || (|applied)) begin
      p_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_reg <= 1'b0;
      p_ch_reg    <= '0;
      p_div_reg   <= '0;
    end else begin
      p_valid_reg <= p_valid_next;
      if (cfg_accept) begin
        p_ch_reg  <= cfg_ch;
        p_div_reg <= cfg_div;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_act_reg;
    logic             clk_out_reg;
    logic             tick_reg;
    logic             wrap;

    assign apply_hit[gi] = p_valid_reg && (p_ch_reg == CH_W'(gi));
    assign wrap          = en[gi] && (cnt_reg == div_act_reg);
    // A pending divisor lands only at a half-period boundary, or at once if the channel is idle.
    assign applied[gi]   = apply_hit[gi] && (wrap || !en[gi]);

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg     <= '0;
        div_act_reg <= DEFAULT_DIV;
        clk_out_reg <= 1'b0;
        tick_reg    <= 1'b0;
      end else if (sync) begin
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
        tick_reg    <= 1'b0;
        if (apply_hit[gi]) begin
          div_act_reg <= p_div_reg;
        end
      end else if (en[gi]) begin
        if (wrap) begin
          cnt_reg     <= '0;
          clk_out_reg <= ~clk_out_reg;
          tick_reg    <= 1'b1;
          if (apply_hit[gi]) begin
            div_act_reg <= p_div_reg;
          end
        end else begin
          cnt_reg  <= cnt_reg + CNT_W'(1);
          tick_reg <= 1'b0;
        end
      end else begin
        tick_reg <= 1'b0;
        if (apply_hit[gi]) begin
          div_act_reg <= p_div_reg;
          cnt_reg     <= '0;
        end
      end
    end

    assign clk_out[gi] = clk_out_reg;
    assign tick[gi]    = tick_reg;
  end

endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of each channel's half-period counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 32'd99_999: divisor loaded into every channel at reset.
REQ-004 Derived CH_W = max(1, clog2(NUM_CH)): width of the channel select field.
REQ-005 The design uses one clock; reset is asynchronous and active-low.
REQ-006 Port clk_in, input, 1: sole clock, all state on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port en, input, NUM_CH: per-channel count enable.
REQ-009 Port sync, input, 1: synchronous restart of all channels.
REQ-010 Port cfg_valid, input, 1: divisor-update request.
REQ-011 Port cfg_ready, output, 1: update slot free.
REQ-012 Port cfg_ch, input, CH_W: channel targeted by the update.
REQ-013 Port cfg_div, input, CNT_W: new divisor (half-period length minus 1).
REQ-014 Port clk_out, output, NUM_CH: divided square-wave outputs, registered.
REQ-015 Port tick, output, NUM_CH: one-cycle pulse on each clk_out toggle, registered.

Function
REQ-016 Each channel SHALL hold cnt[CNT_W] and div_act[CNT_W]; cnt SHALL never exceed div_act.
REQ-017 With en[i]=1 and cnt==div_act: next cycle cnt=0, clk_out[i] inverted, tick[i]=1.
REQ-018 With en[i]=1 and cnt<div_act: cnt increments by 1 and tick[i]=0; the clk_out period is 2*(div_act+1) clk_in cycles.
REQ-019 div_act=0: clk_out[i] toggles every cycle (clk_in/2), tick[i] is high continuously.
REQ-020 With en[i]=0: cnt and clk_out[i] hold and tick[i]=0; re-enabling resumes from the held cnt.
REQ-021 A one-entry pending slot (p_valid, p_ch, p_div) SHALL buffer updates; cfg_ready = ~p_valid, combinational.
REQ-022 Handshake: accept on cfg_valid && cfg_ready; p_valid is set the next cycle and cfg_ready drops then.
REQ-023 An accepted cfg_ch >= NUM_CH SHALL be discarded and p_valid left 0.
REQ-024 The pending divisor SHALL be applied to channel p_ch in the cycle that channel wraps (REQ-017): div_act=p_div, cnt=0, p_valid cleared; cfg_ready is high the following cycle.
REQ-025 If en[p_ch]=0, the pending divisor SHALL be applied on the next cycle without a wrap; cnt=0 and clk_out holds.
REQ-026 Updates never truncate a half-period in progress; the current half-period completes with the old divisor.
REQ-027 sync=1: next cycle every cnt=0, clk_out=0, tick=0; any pending update is applied immediately and p_valid cleared.
REQ-028 sync overrides en and the wrap logic; a cfg accepted in the same cycle as sync is stored in the slot (not applied), and is handled from then on under REQ-024/025.
REQ-029 cfg_valid held while cfg_ready=0 SHALL have no effect; the requester must hold it until accepted.
REQ-030 Counter arithmetic is CNT_W-bit unsigned with no overflow path; the compare is equality only.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously, force every cnt=0, div_act=DEFAULT_DIV, clk_out=0, tick=0, p_valid=0, so cfg_ready=1.
REQ-032 Reset mid-period or with an update pending SHALL discard the update; counting restarts on the first edge after rst_n rises, provided en is set.
REQ-033 No output SHALL glitch; every output is a flop or, for cfg_ready, the inverse of one flop.

Verification
REQ-034 DEFAULT_DIV=3, en=2'b11 after reset -> clk_out[0] rises at cycle 4 and falls at cycle 8; tick[0] pulses at cycles 4, 8, 12.
REQ-035 Write ch0 div=0 -> after the current wrap, clk_out[0] toggles every cycle and tick[0] stays 1.
REQ-036 div=3, cfg ch0 div=1 accepted at cnt=1 -> cfg_ready=0 until the toggle at cnt=3; subsequent toggles every 2 cycles; cfg_ready=1 the cycle after.
REQ-037 en[1]=0 at cnt=2 for 10 cycles -> clk_out[1] frozen, tick[1]=0; toggle lands 2 cycles after re-enable (div=3).
REQ-038 sync pulse mid-count with update pending on ch1 -> next cycle all clk_out=0, cnt=0, ch1 new divisor active, cfg_ready=1.
REQ-039 rst_n low mid-half-period with p_valid=1 -> outputs zero without a clock edge; after release, div_act=DEFAULT_DIV and cfg_ready=1.
